// File: rtl/seq_var_shifter.sv
`default_nettype none
// ============================================================================
// Module      : seq_var_shifter
// Description : Multi-cycle variable shifter with valid/ready handshakes on
//               both sides. It shifts the working register by at most STEP
//               positions per clock. This keeps the datapath narrow on wide
//               operands.
//               Modes: 0=SLL, 1=SRL, 2=SRA, 3=ROL.
// Ports       : clk, reset (async, active-high)
//               in_valid/in_ready   request handshake (in_ready = IDLE)
//               in_data, in_amt, in_mode  request payload
//               out_valid/out_ready result handshake
//               out_data, out_zero  result and its zero flag
// Revision    : 1.0 - initial release
// ============================================================================
module seq_var_shifter #(
    parameter int WIDTH = 8,
    parameter int AW    = 8,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AW-1:0]    in_amt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero
);

    localparam int c_LW = $clog2(WIDTH);
    // The remaining count must be able to hold WIDTH itself (saturated amount).
    localparam int c_RW = c_LW + 1;
    localparam int c_XW = (AW > c_RW) ? AW : c_RW;

    localparam logic [1:0] c_SLL = 2'd0;
    localparam logic [1:0] c_SRL = 2'd1;
    localparam logic [1:0] c_SRA = 2'd2;
    localparam logic [1:0] c_ROL = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [WIDTH-1:0]  r_data;
    logic [c_RW-1:0]   r_rem;
    logic [1:0]        r_mode;
    logic              r_sign;
    logic              r_out_valid;
    logic [WIDTH-1:0]  r_out_data;
    logic              r_out_zero;

    logic [c_XW-1:0]   w_amt_x;
    logic [c_RW-1:0]   w_eff;
    logic [c_RW-1:0]   w_k;
    logic [c_RW-1:0]   w_rem_next;
    logic [WIDTH-1:0]  w_shifted;
    logic [WIDTH-1:0]  w_cand [1:STEP];

    assign in_ready  = (r_state == IDLE);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_zero  = r_out_zero;

    // Effective amount: rotate wraps modulo WIDTH, the other modes saturate
    // at WIDTH so that oversized amounts flush the operand completely.
    assign w_amt_x = c_XW'(in_amt);
    always_comb begin
        w_eff = '0;
        if (in_mode == c_ROL) begin
            w_eff = {1'b0, w_amt_x[c_LW-1:0]};
        end else if (w_amt_x >= c_XW'(WIDTH)) begin
            w_eff = c_RW'(WIDTH);
        end else begin
            w_eff = c_RW'(w_amt_x);
        end
    end

    assign w_k        = (r_rem < c_RW'(STEP)) ? r_rem : c_RW'(STEP);
    assign w_rem_next = r_rem - w_k;

    // One fixed-distance candidate per possible step size. The step mux then
    // picks one, so no full WIDTH-wide barrel shifter is built.
    for (genvar j = 1; j <= STEP; j++) begin : g_step
        assign w_cand[j] =
            (r_mode == c_SLL) ? (r_data << j) :
            (r_mode == c_SRL) ? (r_data >> j) :
            (r_mode == c_SRA) ? (({WIDTH{r_sign}} << (WIDTH - j)) | (r_data >> j)) :
                                ((r_data << j) | (r_data >> (WIDTH - j)));
    end

    always_comb begin
        w_shifted = r_data;
        for (int j = 1; j <= STEP; j++) begin
            if (w_k == c_RW'(j)) begin
                w_shifted = w_cand[j];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_next_state = (w_eff == '0) ? DONE : SHIFT;
            SHIFT:   if (w_rem_next == '0) w_next_state = DONE;
            DONE:    if (out_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data      <= '0;
            r_rem       <= '0;
            r_mode      <= '0;
            r_sign      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_zero  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_data <= in_data;
                        r_mode <= in_mode;
                        r_sign <= in_data[WIDTH-1];
                        r_rem  <= w_eff;
                        if (w_eff == '0) begin
                            r_out_valid <= 1'b1;
                            r_out_data  <= in_data;
                            r_out_zero  <= (in_data == '0);
                        end
                    end
                end
                SHIFT: begin
                    r_data <= w_shifted;
                    r_rem  <= w_rem_next;
                    if (w_rem_next == '0) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_shifted;
                        r_out_zero  <= (w_shifted == '0);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_var_shifter.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_var_shifter
// Description : Self-checking bench for seq_var_shifter. Two instances are
//               used: one with STEP=1 and one with STEP=3, both WIDTH=8,
//               AW=8. They share the reset and the payload inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_var_shifter;

    logic       clk;
    logic       reset;
    logic [7:0] in_data;
    logic [7:0] in_amt;
    logic [1:0] in_mode;

    logic       v1, rdy1, ov1, ordy1, oz1;
    logic [7:0] od1;
    logic       v3, rdy3, ov3, ordy3, oz3;
    logic [7:0] od3;

    int errs   = 0;
    int checks = 0;

    seq_var_shifter #(.WIDTH(8), .AW(8), .STEP(1)) dut1 (
        .clk(clk), .reset(reset),
        .in_valid(v1), .in_ready(rdy1),
        .in_data(in_data), .in_amt(in_amt), .in_mode(in_mode),
        .out_valid(ov1), .out_ready(ordy1),
        .out_data(od1), .out_zero(oz1)
    );

    seq_var_shifter #(.WIDTH(8), .AW(8), .STEP(3)) dut3 (
        .clk(clk), .reset(reset),
        .in_valid(v3), .in_ready(rdy3),
        .in_data(in_data), .in_amt(in_amt), .in_mode(in_mode),
        .out_valid(ov3), .out_ready(ordy3),
        .out_data(od3), .out_zero(oz3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model computed directly from the mode definitions.
    function automatic logic [7:0] ref_shift(input int d, input int amt, input int mode);
        int sv;
        int r;
        case (mode)
            0: return (amt >= 8) ? 8'd0 : 8'((d << amt) & 255);
            1: return (amt >= 8) ? 8'd0 : 8'(d >> amt);
            2: begin
                sv = (d >= 128) ? d - 256 : d;
                return 8'((sv >>> ((amt > 7) ? 7 : amt)) & 255);
            end
            default: begin
                r = amt % 8;
                return 8'(((d << r) | (d >> (8 - r))) & 255);
            end
        endcase
    endfunction

    function automatic int ref_lat(input int amt, input int mode, input int step);
        int eff;
        eff = (mode == 3) ? (amt % 8) : ((amt > 8) ? 8 : amt);
        return 1 + (eff + step - 1) / step;
    endfunction

    // Drives one request with out_ready=1 and measures its latency. The task
    // is entered and left 1ns after a rising edge with the selected DUT idle.
    task automatic run(input bit sel, input logic [7:0] d, input logic [7:0] a,
                       input logic [1:0] m, output int lat,
                       output logic [7:0] q, output logic z);
        in_data = d; in_amt = a; in_mode = m;
        ordy1 = 1'b1; ordy3 = 1'b1;
        if (sel) v3 = 1'b1; else v1 = 1'b1;
        @(posedge clk); #1;
        v1 = 1'b0; v3 = 1'b0;
        lat = 1;
        while (!(sel ? ov3 : ov1) && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        q = sel ? od3 : od1;
        z = sel ? oz3 : oz1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        #12;
        checks++;
        if (ov1 !== 1'b0 || ov3 !== 1'b0) begin
            errs++; $display("FAIL reset_out_valid: got %b/%b want 0/0", ov1, ov3);
        end
        checks++;
        if (od1 !== 8'h00 || od3 !== 8'h00) begin
            errs++; $display("FAIL reset_out_data: got %h/%h want 00/00", od1, od3);
        end
        checks++;
        if (oz1 !== 1'b0 || oz3 !== 1'b0) begin
            errs++; $display("FAIL reset_out_zero: got %b/%b want 0/0", oz1, oz3);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (rdy1 !== 1'b1 || rdy3 !== 1'b1) begin
            errs++; $display("FAIL reset_in_ready: got %b/%b want 1/1", rdy1, rdy3);
        end
    endtask

    task automatic test_sll_walk;
        int lat;
        logic [7:0] q;
        logic z;
        for (int a = 0; a < 8; a++) begin
            run(1'b0, 8'h01, 8'(a), 2'd0, lat, q, z);
            checks++;
            if (q !== 8'(1 << a)) begin
                errs++; $display("FAIL sll_walk_data amt=%0d: got %h want %h", a, q, 8'(1 << a));
            end
            checks++;
            if (lat != 1 + a) begin
                errs++; $display("FAIL sll_walk_latency amt=%0d: got %0d want %0d", a, lat, 1 + a);
            end
        end
        run(1'b0, 8'hA5, 8'd7, 2'd0, lat, q, z);
        checks++;
        if (q !== 8'h80) begin
            errs++; $display("FAIL sll_a5_by7: got %h want 80", q);
        end
        run(1'b0, 8'hA5, 8'd1, 2'd0, lat, q, z);
        checks++;
        if (q !== 8'h4A) begin
            errs++; $display("FAIL sll_a5_by1: got %h want 4a", q);
        end
    endtask

    task automatic test_modes;
        logic [7:0] td [5] = '{8'hA5, 8'hA5, 8'h25, 8'hA5, 8'hA5};
        logic [7:0] ta [5] = '{8'd2,  8'd2,  8'd2,  8'd9,  8'd8};
        logic [1:0] tm [5] = '{2'd1,  2'd2,  2'd2,  2'd3,  2'd3};
        logic [7:0] te [5] = '{8'h29, 8'hE9, 8'h09, 8'h4B, 8'hA5};
        int         tl [5] = '{3, 3, 3, 2, 1};
        int lat;
        logic [7:0] q;
        logic z;
        for (int i = 0; i < 5; i++) begin
            run(1'b0, td[i], ta[i], tm[i], lat, q, z);
            checks++;
            if (q !== te[i]) begin
                errs++; $display("FAIL modes_data case=%0d: got %h want %h", i, q, te[i]);
            end
            checks++;
            if (lat != tl[i]) begin
                errs++; $display("FAIL modes_latency case=%0d: got %0d want %0d", i, lat, tl[i]);
            end
        end
    endtask

    task automatic test_saturation;
        int lat;
        logic [7:0] q;
        logic z;
        run(1'b1, 8'h80, 8'd20, 2'd1, lat, q, z);
        checks++;
        if (q !== 8'h00 || z !== 1'b1) begin
            errs++; $display("FAIL sat_srl: got %h zero=%b want 00 zero=1", q, z);
        end
        checks++;
        if (lat != 4) begin
            errs++; $display("FAIL sat_srl_latency: got %0d want 4", lat);
        end
        run(1'b1, 8'h80, 8'd200, 2'd2, lat, q, z);
        checks++;
        if (q !== 8'hFF || z !== 1'b0) begin
            errs++; $display("FAIL sat_sra: got %h zero=%b want ff zero=0", q, z);
        end
        checks++;
        if (lat != 4) begin
            errs++; $display("FAIL sat_sra_latency: got %0d want 4", lat);
        end
    endtask

    task automatic test_backpressure;
        int n;
        ordy1 = 1'b0;
        in_data = 8'h03; in_amt = 8'd2; in_mode = 2'd0; v1 = 1'b1;
        @(posedge clk); #1;
        v1 = 1'b0;
        n = 0;
        while (!ov1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        // A competing request must not disturb the held result.
        in_data = 8'hFF; in_amt = 8'd1; v1 = 1'b1;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (ov1 !== 1'b1 || od1 !== 8'h0C || rdy1 !== 1'b0) begin
                errs++;
                $display("FAIL backpressure_hold cyc=%0d: got valid=%b data=%h ready=%b want 1 0c 0",
                         c, ov1, od1, rdy1);
            end
            @(posedge clk); #1;
        end
        ordy1 = 1'b1; v1 = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (ov1 !== 1'b0 || rdy1 !== 1'b1) begin
            errs++; $display("FAIL backpressure_release: got valid=%b ready=%b want 0 1", ov1, rdy1);
        end
    endtask

    task automatic test_reset_mid;
        int lat;
        logic [7:0] q;
        logic z;
        ordy1 = 1'b1;
        in_data = 8'h01; in_amt = 8'd6; in_mode = 2'd0; v1 = 1'b1;
        @(posedge clk); #1;              // accept edge
        v1 = 1'b0;
        @(posedge clk); @(posedge clk);  // into the third SHIFT cycle
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if (ov1 !== 1'b0 || od1 !== 8'h00) begin
            errs++; $display("FAIL reset_mid_outputs: got valid=%b data=%h want 0 00", ov1, od1);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (rdy1 !== 1'b1 || ov1 !== 1'b0) begin
            errs++; $display("FAIL reset_mid_ready: got ready=%b valid=%b want 1 0", rdy1, ov1);
        end
        run(1'b0, 8'h80, 8'd1, 2'd1, lat, q, z);
        checks++;
        if (q !== 8'h40) begin
            errs++; $display("FAIL reset_mid_next: got %h want 40", q);
        end
    endtask

    task automatic test_back_to_back(input bit sel);
        logic [7:0] rd [20];
        logic [7:0] ra [20];
        logic [1:0] rm [20];
        logic [8:0] exp_q [$];
        logic [8:0] e;
        logic [7:0] r;
        int idx, got, cyc;
        bit acc, hs;
        for (int i = 0; i < 20; i++) begin
            rd[i] = 8'($urandom);
            ra[i] = 8'($urandom_range(0, 20));
            rm[i] = 2'($urandom);
        end
        idx = 0; got = 0; cyc = 0;
        while (got < 20 && cyc < 1500) begin
            if (idx < 20) begin
                in_data = rd[idx]; in_amt = ra[idx]; in_mode = rm[idx];
            end
            if (sel) begin
                v3 = (idx < 20); ordy3 = 1'($urandom);
                acc = v3 && rdy3; hs = ov3 && ordy3;
            end else begin
                v1 = (idx < 20); ordy1 = 1'($urandom);
                acc = v1 && rdy1; hs = ov1 && ordy1;
            end
            @(posedge clk); #1;
            cyc++;
            if (hs) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errs++; $display("FAIL b2b_extra_result sel=%0d: got a result want none", sel);
                end else begin
                    e = exp_q.pop_front();
                    if ({sel ? oz3 : oz1, sel ? od3 : od1} !== e) begin
                        errs++;
                        $display("FAIL b2b_result sel=%0d n=%0d: got zero=%b data=%h want zero=%b data=%h",
                                 sel, got, sel ? oz3 : oz1, sel ? od3 : od1, e[8], e[7:0]);
                    end
                end
                got++;
            end
            // Result registers hold their value after the handshake edge, so
            // they are read before the new accept is modelled.
            if (acc) begin
                r = ref_shift(int'(rd[idx]), int'(ra[idx]), int'(rm[idx]));
                exp_q.push_back({(r == 8'h00), r});
                idx++;
            end
        end
        v1 = 1'b0; v3 = 1'b0;
        checks++;
        if (got != 20 || idx != 20 || exp_q.size() != 0) begin
            errs++;
            $display("FAIL b2b_count sel=%0d: got results=%0d accepts=%0d pending=%0d want 20 20 0",
                     sel, got, idx, exp_q.size());
        end
    endtask

    // A short random sweep on the STEP=3 instance also covers latency.
    task automatic test_random_latency;
        int lat, a, m;
        logic [7:0] d, q;
        logic z;
        for (int i = 0; i < 8; i++) begin
            d = 8'($urandom); a = $urandom_range(0, 255); m = $urandom_range(0, 3);
            run(1'b1, d, 8'(a), 2'(m), lat, q, z);
            checks++;
            if (q !== ref_shift(int'(d), a, m) || lat != ref_lat(a, m, 3)) begin
                errs++;
                $display("FAIL rand_step3 d=%h a=%0d m=%0d: got %h lat=%0d want %h lat=%0d",
                         d, a, m, q, lat, ref_shift(int'(d), a, m), ref_lat(a, m, 3));
            end
        end
    endtask

    initial begin
        v1 = 1'b0; v3 = 1'b0; ordy1 = 1'b1; ordy3 = 1'b1;
        in_data = 8'h00; in_amt = 8'h00; in_mode = 2'd0;
        test_reset();
        test_sll_walk();
        test_modes();
        test_saturation();
        test_backpressure();
        test_reset_mid();
        test_random_latency();
        test_back_to_back(1'b0);
        test_back_to_back(1'b1);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
`default_nettype wire
